// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared types and constants for the exception sequencer:
//   - exc_state_e : sequencer FSM states
//   - CAUSE_*     : latched exception cause codes
//   - PCSRC_*     : PC-source mux selector values
//   - vec_addr()  : exception-vector address helper
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAVE_EPC = 3'd1,
        ST_READ_VEC = 3'd2,
        ST_LOAD_PC  = 3'd3,
        ST_DONE     = 3'd4
    } exc_state_e;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;

    localparam logic [2:0] PCSRC_ALU = 3'b000;
    localparam logic [2:0] PCSRC_VEC = 3'b110;

    // Vector table entries are one byte apart, so the cause is a plain byte offset.
    function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [1:0] cause);
        return base + {30'd0, cause};
    endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// -----------------------------------------------------------------------------
// exc_sequencer_if
// Bundle between the exception sequencer and the processor datapath.
//   Exception events : exc_opcode, exc_ovf, exc_div0 (levels)
//   Memory           : mem_byte (read data), mem_read, mem_addr
//   Datapath control : exc_active, epc_write, alu_pc_minus4, pc_src_sel, pc_write
//   Status           : exc_cause, exc_done
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface exc_sequencer_if;

    logic        exc_opcode;
    logic        exc_ovf;
    logic        exc_div0;
    logic [7:0]  mem_byte;
    logic        exc_active;
    logic        epc_write;
    logic        alu_pc_minus4;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [2:0]  pc_src_sel;
    logic        pc_write;
    logic [1:0]  exc_cause;
    logic        exc_done;

    modport master (
        input  exc_opcode, exc_ovf, exc_div0, mem_byte,
        output exc_active, epc_write, alu_pc_minus4, mem_read, mem_addr,
               pc_src_sel, pc_write, exc_cause, exc_done
    );

    modport slave (
        output exc_opcode, exc_ovf, exc_div0, mem_byte,
        input  exc_active, epc_write, alu_pc_minus4, mem_read, mem_addr,
               pc_src_sel, pc_write, exc_cause, exc_done
    );

endinterface

// File: rtl/exc_prio_enc.sv
// -----------------------------------------------------------------------------
// exc_prio_enc
// Combinational priority encoder for exception events: opcode > overflow > div0.
// Macro EXC_DIV0_EN: when defined, exc_div0 produces cause 2; otherwise the
// input is ignored and cause 2 is never produced.
//   exc_opcode, exc_ovf, exc_div0 : event levels
//   valid                         : some enabled event is present
//   cause                         : code of the highest-priority event
// -----------------------------------------------------------------------------
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic       valid,
    output logic [1:0] cause
);

    // Fixed-priority selection of the pending event.
    always_comb begin
        valid = 1'b0;
        cause = CAUSE_OPCODE;
        if (exc_opcode) begin
            valid = 1'b1;
            cause = CAUSE_OPCODE;
        end else if (exc_ovf) begin
            valid = 1'b1;
            cause = CAUSE_OVF;
`ifdef EXC_DIV0_EN
        end else if (exc_div0) begin
            valid = 1'b1;
            cause = CAUSE_DIV0;
`endif
        end else begin
            valid = 1'b0;
            cause = CAUSE_OPCODE;
        end
    end

`ifndef EXC_DIV0_EN
    // Divide-by-zero is not handled in this build; the port stays for pin compatibility.
    logic unused_div0_s;
    assign unused_div0_s = exc_div0;
`endif

endmodule

// File: rtl/exc_sequencer.sv
// -----------------------------------------------------------------------------
// exc_sequencer
// Multicycle exception sequencer. On an exception it saves PC-4 into EPC,
// reads the vector byte at VEC_BASE+cause and loads it into PC through the
// PC-source mux, then pulses exc_done for one cycle.
// Macro EXC_DIV0_EN enables divide-by-zero as cause 2 (see exc_prio_enc).
// Parameters: MEM_LAT (1..4) memory read latency, VEC_BASE vector base address.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : exc_sequencer_if.master (events, memory strobes, datapath control)
// All outputs are registers or decodes of the state register only.
// -----------------------------------------------------------------------------
module exc_sequencer
    import exc_pkg::*;
#(
    parameter int unsigned MEM_LAT  = 32'd1,
    parameter logic [31:0] VEC_BASE = 32'd253
) (
    input  logic            clk,
    input  logic            reset,
    exc_sequencer_if.master bus
);

    // Counter value of the final READ_VEC cycle.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 32'd1);

    exc_state_e  state_r;
    exc_state_e  state_nx_s;
    logic        enc_valid_s;
    logic [1:0]  enc_cause_s;
    logic [1:0]  cause_r;
    logic [1:0]  lat_cnt_r;
    logic        lat_last_s;
    logic [31:0] mem_addr_r;

    logic        exc_active_s;
    logic        epc_write_s;
    logic        alu_pc_minus4_s;
    logic        mem_read_s;
    logic        pc_write_s;
    logic [2:0]  pc_src_sel_s;
    logic        exc_done_s;

    exc_prio_enc u_prio_enc (
        .exc_opcode (bus.exc_opcode),
        .exc_ovf    (bus.exc_ovf),
        .exc_div0   (bus.exc_div0),
        .valid      (enc_valid_s),
        .cause      (enc_cause_s)
    );

    assign lat_last_s = (lat_cnt_r == LAT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; events are only looked at in IDLE.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (enc_valid_s) begin
                    state_nx_s = ST_SAVE_EPC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SAVE_EPC: state_nx_s = ST_READ_VEC;
            ST_READ_VEC: begin
                if (lat_last_s) begin
                    state_nx_s = ST_LOAD_PC;
                end else begin
                    state_nx_s = ST_READ_VEC;
                end
            end
            ST_LOAD_PC:  state_nx_s = ST_DONE;
            ST_DONE:     state_nx_s = ST_IDLE;
            default:     state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from state only.
    always_comb begin
        exc_active_s    = 1'b0;
        epc_write_s     = 1'b0;
        alu_pc_minus4_s = 1'b0;
        mem_read_s      = 1'b0;
        pc_write_s      = 1'b0;
        pc_src_sel_s    = PCSRC_ALU;
        exc_done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                exc_active_s = 1'b0;
            end
            ST_SAVE_EPC: begin
                exc_active_s    = 1'b1;
                epc_write_s     = 1'b1;
                alu_pc_minus4_s = 1'b1;
            end
            ST_READ_VEC: begin
                exc_active_s = 1'b1;
                mem_read_s   = 1'b1;
            end
            ST_LOAD_PC: begin
                exc_active_s = 1'b1;
                pc_write_s   = 1'b1;
                pc_src_sel_s = PCSRC_VEC;
            end
            ST_DONE: begin
                exc_done_s = 1'b1;
            end
            default: begin
                exc_active_s = 1'b0;
            end
        endcase
    end

    // Cause latch, read-latency counter and vector address register.
    // The address is loaded during SAVE_EPC so it is already stable in the
    // first READ_VEC cycle, and then held until the next sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_r    <= CAUSE_OPCODE;
            lat_cnt_r  <= 2'd0;
            mem_addr_r <= 32'd0;
        end else begin
            if ((state_r == ST_IDLE) && enc_valid_s) begin
                cause_r <= enc_cause_s;
            end
            if (state_r == ST_SAVE_EPC) begin
                mem_addr_r <= vec_addr(VEC_BASE, cause_r);
            end
            if ((state_r == ST_READ_VEC) && !lat_last_s) begin
                lat_cnt_r <= lat_cnt_r + 2'd1;
            end else begin
                lat_cnt_r <= 2'd0;
            end
        end
    end

    assign bus.exc_active    = exc_active_s;
    assign bus.epc_write     = epc_write_s;
    assign bus.alu_pc_minus4 = alu_pc_minus4_s;
    assign bus.mem_read      = mem_read_s;
    assign bus.mem_addr      = mem_addr_r;
    assign bus.pc_src_sel    = pc_src_sel_s;
    assign bus.pc_write      = pc_write_s;
    assign bus.exc_cause     = cause_r;
    assign bus.exc_done      = exc_done_s;

endmodule
